// File: rtl/reg_bank32_pkg.sv
// Shared constants and payload types for the general register bank.
// The init constants are also consumed by the testbench and the boot-code linker script.
package reg_bank32_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_GP   = 5'd28;
  localparam logic [AW-1:0] REG_SP   = 5'd29;

  localparam logic [XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_2ffc;
  localparam logic [XLEN-1:0] GP_INIT_DEFAULT = 32'h0000_1800;

  // Write-back payload as seen by the bank
  typedef struct packed {
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
  } wb_req_t;

  // Reset image for one register index
  function automatic logic [XLEN-1:0] reset_value(input int idx,
                                                  input logic [XLEN-1:0] gp,
                                                  input logic [XLEN-1:0] sp);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx == int'(REG_GP)) v = gp;
    if (idx == int'(REG_SP)) v = sp;
    return v;
  endfunction

endpackage

// File: rtl/reg_bank32_decoder5_32.sv
// 5-bit address plus enable to a 32-bit one-hot strobe; also reused for data-memory bank select.
module decoder5_32 (
  input  logic        i_en,
  input  logic [4:0]  i_addr,
  output logic [31:0] o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    if (i_en) o_onehot_c[i_addr] = 1'b1;
  end

endmodule

// File: rtl/reg_bank32.sv
// Storage half of the CPU register file: 32 x 32-bit registers, one write per clock,
// exposed as a flat image so downstream read muxes stay purely combinational.
module reg_bank32
  import reg_bank32_pkg::*;
#(
  parameter logic [31:0] SP_INIT  = SP_INIT_DEFAULT,
  parameter logic [31:0] GP_INIT  = GP_INIT_DEFAULT,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [XLEN-1:0]      wd,
  output logic [NREG*XLEN-1:0] D,
  output logic [15:0]          wr_cnt,
  output logic [AW-1:0]        last_wa,
  output logic [XLEN-1:0]      last_wd
);

  logic          w_commit;
  logic [31:0]   w_strobe;
  wb_req_t       w_req;
  wb_req_t       r_last;
  logic [15:0]   r_wr_cnt;

  // A write to r0 is dropped entirely when r0 is hardwired, including the debug trackers
  assign w_commit = we & (~ZERO_REG | (wa != REG_ZERO));
  assign w_req    = '{wa: wa, wd: wd};

  decoder5_32 u_dec (
    .i_en       (w_commit),
    .i_addr     (wa),
    .o_onehot_c (w_strobe)
  );

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if ((gi == 0) && ZERO_REG) begin : g_zero
      logic w_unused_strobe;
      assign w_unused_strobe      = w_strobe[gi];
      assign D[gi*XLEN +: XLEN]   = '0;
    end else begin : g_flop
      localparam logic [XLEN-1:0] RST_VAL = reset_value(gi, GP_INIT, SP_INIT);
      logic [XLEN-1:0] r_q;

      always_ff @(posedge clk or posedge clr) begin
        if (clr)               r_q <= RST_VAL;
        else if (w_strobe[gi]) r_q <= wd;
      end

      assign D[gi*XLEN +: XLEN] = r_q;
    end
  end

  // Commit counter wraps silently; last-write tracker for debug
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wr_cnt <= '0;
      r_last   <= '0;
    end else if (w_commit) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
      r_last   <= w_req;
    end
  end

  assign wr_cnt  = r_wr_cnt;
  assign last_wa = r_last.wa;
  assign last_wd = r_last.wd;

endmodule
